change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Payout end of the vending machine's coin path. The vending machine accepts Rs10/Rs20 coins; this block pays change back out.
- Accepts a change amount from the vending machine and drives a coin hopper, one coin per request/acknowledge handshake, greedy Rs20-first.
- Tracks the Rs20 and Rs10 coin stock in the hopper and flags a shortfall when it cannot pay exact change.

Parameters:
- CHG_W, 4, width of the change amount in Rs10 units (max 15 = Rs150).
- STK_W, 4, width of each coin stock counter; saturates at 2^STK_W-1.
- GAP_CYC, 2, idle cycles between coin requests, after each ack.
- ACK_TO, 16, cycles to wait for coin_ack before declaring a jam.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- chg_valid  in  1  change request; accepted when chg_valid && chg_ready
- chg_amount  in  CHG_W  change to pay, in Rs10 units
- chg_ready  out  1  high only in IDLE
- coin20_req  out  1  request one Rs20 coin; held until ack
- coin10_req  out  1  request one Rs10 coin; held until ack
- coin_ack  in  1  hopper has dropped the requested coin
- load20  in  1  refill pulse, +1 Rs20 coin
- load10  in  1  refill pulse, +1 Rs10 coin
- stock20  out  STK_W  Rs20 coins held
- stock10  out  STK_W  Rs10 coins held
- owed  out  CHG_W  change still unpaid, in Rs10 units
- done  out  1  one-cycle pulse when owed reaches 0
- short_fault  out  1  sticky: stock cannot cover owed
- jam_fault  out  1  sticky: ack timeout
- clr_fault  in  1  clears both faults; returns the FSM to IDLE

Behaviour:
- Reset values (async): state IDLE, chg_ready=1, all *_req=0, stock20=stock10=0, owed=0, done=0, both faults=0, timer=0.
- States and transitions:
  - IDLE: on accept, owed<=chg_amount. If chg_amount=0, pulse done next cycle and stay in IDLE. Otherwise go to SELECT.
  - SELECT (1 cycle):
    - If owed=0 → DONE.
    - Else if owed>=2 and stock20>0 → REQ20.
    - Else if stock10>0 → REQ10.
    - Else → FAULT with short_fault=1.
  - REQ20 / REQ10: the corresponding req is high, exactly one req high at a time.
    - On coin_ack: owed -= 2 (or 1), stock -= 1, req drops the next cycle, go to GAP.
    - Timer counts cycles in REQ. If the timer reaches ACK_TO without an ack → FAULT with jam_fault=1; req drops, owed and stock are unchanged.
  - GAP: wait GAP_CYC cycles → SELECT.
  - DONE: done=1 for one cycle → IDLE.
  - FAULT: chg_ready=0, reqs=0, owed holds its value for inspection. clr_fault → IDLE, owed<=0, faults<=0.
- Latency: request accepted at cycle N → first req asserted at cycle N+2.
- coin_ack outside REQ20/REQ10 is ignored; no state or counter change.
- An ack arriving in the same cycle the timeout expires counts as an ack; no jam.
- owed=1 with stock10=0 and stock20>0 → short_fault. The block never overpays.
- Refill:
  - load20/load10 increment the matching stock in any state, saturating at max.
  - A load and a dispense of the same denomination in the same cycle leave the stock unchanged.
  - A load during FAULT does not auto-resume; clr_fault is required.
- Stock counters never underflow; a dispense is only issued when stock>0.
- chg_valid outside IDLE is ignored; there is no queueing.
- rst mid-payout: all outputs return to reset values immediately, including stock counts.

Decomposition:
- Shared package:
  - State enum (IDLE, SELECT, REQ20, REQ10, GAP, DONE, FAULT).
  - Denomination constants: DEN20=2, DEN10=1 in Rs10 units.
  - Default CHG_W and STK_W, shared with vending_machine's change output.
- One sub-module, coin_stock: a saturating up/down counter with inc, dec and count. It is instantiated twice, once for Rs20 and once for Rs10.

Test Plan:
- load20×3, load10×2; chg_amount=5 → coin20_req acked twice, then coin10_req acked once; owed 5→3→1→0; done pulse; stock20=1, stock10=1.
- stock20=0, stock10=2; chg_amount=3 → two Rs10 coins dispensed, then short_fault=1 with owed=1; clr_fault → IDLE, owed=0.
- stock20=2, stock10=0; chg_amount=1 → short_fault immediately, no req asserted, stock20 stays 2.
- coin20_req held with no ack for ACK_TO=16 cycles → jam_fault=1, req=0, owed=2, stock20 unchanged. Ack on exactly cycle 16 → treated as an ack, no jam.
- Hold stock at 15 with load20 pulses, then a dispense ack coinciding with load20 → stock20 stays 15. Further load20 pulses at 15 → stock20 saturates at 15.
- rst asserted mid-REQ10 → req drops asynchronously; all counters and flags return to 0. chg_amount=0 request → done pulse with no req.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change payout path.
// Denominations are expressed in Rs10 units so owed arithmetic stays small.
package change_dispenser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ20,
        REQ10,
        GAP,
        DONE,
        FAULT
    } state_e;

    localparam int DEN20     = 2;
    localparam int DEN10     = 1;
    localparam int CHG_W_DEF = 4;
    localparam int STK_W_DEF = 4;

endpackage

// File: rtl/change_dispenser_coin_stock.sv
// Saturating up/down coin counter for one hopper denomination.
// A simultaneous refill and dispense cancel out; the count never wraps.
module coin_stock #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            if (count_q != '1) count_d = count_q + W'(1);
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/change_dispenser.sv
// Pays change out of a two-denomination hopper, greedy Rs20-first, one coin per
// req/ack handshake (req held until coin_ack), with shortfall and jam detection.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int CHG_W   = CHG_W_DEF,
    parameter int STK_W   = STK_W_DEF,
    parameter int GAP_CYC = 2,
    parameter int ACK_TO  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chg_valid,
    input  logic [CHG_W-1:0] chg_amount,
    output logic             chg_ready,
    output logic             coin20_req,
    output logic             coin10_req,
    input  logic             coin_ack,
    input  logic             load20,
    input  logic             load10,
    output logic [STK_W-1:0] stock20,
    output logic [STK_W-1:0] stock10,
    output logic [CHG_W-1:0] owed,
    output logic             done,
    output logic             short_fault,
    output logic             jam_fault,
    input  logic             clr_fault
);

    // One timer serves both the ack timeout and the inter-coin gap.
    localparam int TMR_MAX = (ACK_TO > GAP_CYC) ? ACK_TO : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_e             state_q, state_d;
    logic [CHG_W-1:0]   owed_q, owed_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               zero_done_q, zero_done_d;
    logic               short_q, short_d;
    logic               jam_q, jam_d;
    logic               dec20, dec10;

    coin_stock #(.W(STK_W)) u_stock20 (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (load20),
        .dec_i   (dec20),
        .count_o (stock20)
    );

    coin_stock #(.W(STK_W)) u_stock10 (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (load10),
        .dec_i   (dec10),
        .count_o (stock10)
    );

    always_comb begin
        state_d     = state_q;
        owed_d      = owed_q;
        timer_d     = '0;
        zero_done_d = 1'b0;
        short_d     = short_q;
        jam_d       = jam_q;
        dec20       = 1'b0;
        dec10       = 1'b0;
        case (state_q)
            IDLE: begin
                if (chg_valid) begin
                    owed_d = chg_amount;
                    if (chg_amount == '0) zero_done_d = 1'b1;
                    else                  state_d     = SELECT;
                end
            end
            SELECT: begin
                if (owed_q == '0)                                      state_d = DONE;
                else if (owed_q >= CHG_W'(DEN20) && stock20 != '0)     state_d = REQ20;
                else if (stock10 != '0)                                state_d = REQ10;
                else begin
                    state_d = FAULT;
                    short_d = 1'b1;
                end
            end
            // An ack in the final timeout cycle wins over the jam.
            REQ20: begin
                if (coin_ack) begin
                    owed_d  = owed_q - CHG_W'(DEN20);
                    dec20   = 1'b1;
                    state_d = GAP;
                end else if (timer_q == TMR_W'(ACK_TO - 1)) begin
                    state_d = FAULT;
                    jam_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            REQ10: begin
                if (coin_ack) begin
                    owed_d  = owed_q - CHG_W'(DEN10);
                    dec10   = 1'b1;
                    state_d = GAP;
                end else if (timer_q == TMR_W'(ACK_TO - 1)) begin
                    state_d = FAULT;
                    jam_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            GAP: begin
                if (timer_q >= TMR_W'(GAP_CYC - 1)) state_d = SELECT;
                else                                 timer_d = timer_q + TMR_W'(1);
            end
            DONE: state_d = IDLE;
            FAULT: begin
                if (clr_fault) begin
                    state_d = IDLE;
                    owed_d  = '0;
                    short_d = 1'b0;
                    jam_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owed_q      <= '0;
            timer_q     <= '0;
            zero_done_q <= 1'b0;
            short_q     <= 1'b0;
            jam_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owed_q      <= owed_d;
            timer_q     <= timer_d;
            zero_done_q <= zero_done_d;
            short_q     <= short_d;
            jam_q       <= jam_d;
        end
    end

    assign chg_ready   = (state_q == IDLE);
    assign coin20_req  = (state_q == REQ20);
    assign coin10_req  = (state_q == REQ10);
    assign owed        = owed_q;
    assign done        = (state_q == DONE) || zero_done_q;
    assign short_fault = short_q;
    assign jam_fault   = jam_q;

endmodule
